ps2_key_matrix: RTL



---
 rtl/ps2_key_matrix.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_matrix.sv
// PS/2 set-2 scancode to keyboard-matrix translator with a host-writable key map,
// prefix/pause parsing, prefix timeout, auxiliary keys, global clear and joystick merge.
module ps2_key_matrix #(
  parameter  int ROWS     = 9,
  parameter  int COLS     = 8,
  parameter  int JOY_BITS = 5,
  parameter  int JOY_ROW  = 4,
  parameter  int TIMEOUT  = 65535,
  localparam int RW       = $clog2(ROWS + 1),
  localparam int CW       = $clog2(COLS),
  localparam int MW       = 1 + RW + CW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scan_valid,
  input  logic [7:0]           scan,
  input  logic                 release_all,
  input  logic                 map_we,
  input  logic [8:0]           map_addr,
  input  logic [MW-1:0]        map_data,
  input  logic [ROWS-1:0]      row_sel,
  input  logic [JOY_BITS-1:0]  joystick,
  output logic [COLS-1:0]      col_out,
  output logic [COLS-1:0]      aux_keys,
  output logic [ROWS*COLS-1:0] key_state
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] AUX_ROW = RW'(ROWS);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_REL, S_EXT_REL, S_PAUSE} state_t;

  state_t          state, state_n;
  logic [2:0]      pause_cnt, pause_n;
  logic [TW-1:0]   tmo_cnt;
  logic            ev_fire, ev_make, ev_ext, clr_fire;

  // Pipeline: stage 1 holds the lookup address, stage 2 sits beside the RAM output.
  logic [8:0]      addr_q;
  logic            ev_q1, make_q1, clr_q1;
  logic            ev_q2, make_q2, clr_q2;
  logic [MW-1:0]   ram_q;
  logic [MW-1:0]   map_mem [512];

  logic [RW-1:0]   ev_row;
  logic [CW-1:0]   ev_col;
  logic [COLS-1:0] joy_ext;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_n  = state;
    pause_n  = pause_cnt;
    ev_fire  = 1'b0;
    ev_make  = 1'b0;
    ev_ext   = 1'b0;
    clr_fire = 1'b0;
    if (scan_valid) begin
      unique case (state)
        S_IDLE: begin
          if (scan == 8'hE0)      state_n = S_EXT;
          else if (scan == 8'hF0) state_n = S_REL;
          else if (scan == 8'hE1) begin
            state_n = S_PAUSE;
            pause_n = 3'd7;
          end
          else if (scan == 8'hAA || scan == 8'hFF) clr_fire = 1'b1;
          else begin
            ev_fire = 1'b1;
            ev_make = 1'b1;
          end
        end
        S_EXT: begin
          if (scan == 8'hF0) state_n = S_EXT_REL;
          else if (scan != 8'hE0) begin
            ev_fire = 1'b1;
            ev_make = 1'b1;
            ev_ext  = 1'b1;
            state_n = S_IDLE;
          end
        end
        S_REL: begin
          ev_fire = 1'b1;
          state_n = S_IDLE;
        end
        S_EXT_REL: begin
          ev_fire = 1'b1;
          ev_ext  = 1'b1;
          state_n = S_IDLE;
        end
        S_PAUSE: begin
          pause_n = pause_cnt - 3'd1;
          if (pause_cnt <= 3'd1) begin
            pause_n = 3'd0;
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end else if (state != S_IDLE && tmo_cnt == TW'(TIMEOUT - 1)) begin
      // Prefix abandoned: fall back to IDLE silently.
      state_n = S_IDLE;
      pause_n = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pause_cnt <= 3'd0;
      tmo_cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers sample together.
      state     <= state_n;
      pause_cnt <= pause_n;
      if (scan_valid || state == S_IDLE) tmo_cnt <= '0;
      else                               tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // NOTE: the map RAM and its read register have no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (map_we) map_mem[map_addr] <= map_data;
    ram_q <= map_mem[addr_q];
  end

  assign ev_row = ram_q[CW +: RW];
  assign ev_col = ram_q[CW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      ev_q1     <= 1'b0;
      make_q1   <= 1'b0;
      clr_q1    <= 1'b0;
      ev_q2     <= 1'b0;
      make_q2   <= 1'b0;
      clr_q2    <= 1'b0;
      key_state <= '0;
      aux_keys  <= '0;
    end else begin
      addr_q  <= {ev_ext, scan};
      ev_q1   <= ev_fire;
      make_q1 <= ev_make;
      clr_q1  <= clr_fire;
      ev_q2   <= ev_q1;
      make_q2 <= make_q1;
      clr_q2  <= clr_q1;
      if (release_all || clr_q2) begin
        key_state <= '0;
        aux_keys  <= '0;
      end else if (ev_q2 && ram_q[MW-1]) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            if (ev_row == RW'(r) && ev_col == CW'(c)) key_state[r*COLS+c] <= make_q2;
          end
        end
        for (int c = 0; c < COLS; c++) begin
          if (ev_row == AUX_ROW && ev_col == CW'(c)) aux_keys[c] <= make_q2;
        end
      end
    end
  end

  always_comb begin
    joy_ext               = '0;
    joy_ext[JOY_BITS-1:0] = joystick;
  end

  always_comb begin
    col_out = '1;
    for (int c = 0; c < COLS; c++) begin
      logic acc;
      acc = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        if (!row_sel[r]) begin
          acc = acc | key_state[r*COLS+c];
          if (r == JOY_ROW) acc = acc | joy_ext[c];
        end
      end
      col_out[c] = ~acc;
    end
  end

endmodule
